// File: rtl/elbeth_load_store_unit.sv
// Load/store initiator for the ELBETH data-memory port: alignment checks, byte-lane
// strobes and store replication, response timeout, and extended load data.
module elbeth_load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_signed,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_except,
  output logic [3:0]  lsu_except_src,
  output logic        dmem_en,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_out_data,
  output logic [3:0]  dmem_rw,
  input  logic [31:0] dmem_in_data,
  input  logic        dmem_ready,
  input  logic        dmem_except,
  input  logic [3:0]  dmem_except_src
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic        local_q, local_d;
  logic [3:0]  lcode_q, lcode_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        en_d;
  logic [31:0] addr_d, odata_d, rdata_d;
  logic [3:0]  rw_d, src_d;
  logic        exc_d;

  logic [3:0]  strb;
  logic [31:0] wrep;
  logic        misalign;
  logic [31:0] shifted, load_val;

  assign lsu_busy = (state_q != IDLE);
  assign lsu_done = (state_q == RESP);

  always_comb begin
    strb = 4'b1111;
    wrep = lsu_wdata;
    case (lsu_size)
      2'b00: begin
        strb = 4'b0001 << lsu_addr[1:0];
        wrep = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        strb = 4'b0011 << lsu_addr[1:0];
        wrep = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
    misalign = ((lsu_size == 2'b01) && lsu_addr[0]) ||
               ((lsu_size == 2'b10) && (lsu_addr[1:0] != 2'b00));
  end

  always_comb begin
    shifted  = dmem_in_data >> {lane_q, 3'b000};
    load_val = dmem_in_data;
    case (size_q)
      2'b00:   load_val = sgn_q ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h000000, shifted[7:0]};
      2'b01:   load_val = sgn_q ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0000, shifted[15:0]};
      default: load_val = dmem_in_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    local_d = local_q;
    lcode_d = lcode_q;
    cnt_d   = cnt_q;
    en_d    = dmem_en;
    addr_d  = dmem_addr;
    odata_d = dmem_out_data;
    rw_d    = dmem_rw;
    rdata_d = lsu_rdata;
    exc_d   = lsu_except;
    src_d   = lsu_except_src;
    case (state_q)
      IDLE: begin
        if (lsu_req) begin
          we_d    = lsu_we;
          size_d  = lsu_size;
          sgn_d   = lsu_signed;
          lane_d  = lsu_addr[1:0];
          cnt_d   = '0;
          state_d = ACCESS;
          // Local faults spend one ACCESS cycle with the bus idle, so their
          // completion lands on the same edge as the fastest bus access.
          if (lsu_size == 2'b11) begin
            local_d = 1'b1;
            lcode_d = 4'h4;
          end else if (misalign) begin
            local_d = 1'b1;
            lcode_d = lsu_we ? 4'h2 : 4'h1;
          end else begin
            local_d = 1'b0;
            en_d    = 1'b1;
            addr_d  = {lsu_addr[31:2], 2'b00};
            rw_d    = lsu_we ? strb : 4'b0000;
            odata_d = wrep;
          end
        end
      end
      ACCESS: begin
        if (local_q) begin
          state_d = RESP;
          rdata_d = '0;
          exc_d   = 1'b1;
          src_d   = lcode_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (dmem_except) begin
            state_d = RESP;
            en_d    = 1'b0;
            rdata_d = '0;
            exc_d   = 1'b1;
            src_d   = dmem_except_src;
          end else if (dmem_ready) begin
            state_d = RESP;
            en_d    = 1'b0;
            rdata_d = we_q ? '0 : load_val;
            exc_d   = 1'b0;
            src_d   = 4'h0;
          end else if (cnt_q == TMO_LAST) begin
            state_d = RESP;
            en_d    = 1'b0;
            rdata_d = '0;
            exc_d   = 1'b1;
            src_d   = 4'h3;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      sgn_q          <= 1'b0;
      lane_q         <= 2'b00;
      local_q        <= 1'b0;
      lcode_q        <= 4'h0;
      cnt_q          <= '0;
      dmem_en        <= 1'b0;
      dmem_addr      <= '0;
      dmem_out_data  <= '0;
      dmem_rw        <= '0;
      lsu_rdata      <= '0;
      lsu_except     <= 1'b0;
      lsu_except_src <= '0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      size_q         <= size_d;
      sgn_q          <= sgn_d;
      lane_q         <= lane_d;
      local_q        <= local_d;
      lcode_q        <= lcode_d;
      cnt_q          <= cnt_d;
      dmem_en        <= en_d;
      dmem_addr      <= addr_d;
      dmem_out_data  <= odata_d;
      dmem_rw        <= rw_d;
      lsu_rdata      <= rdata_d;
      lsu_except     <= exc_d;
      lsu_except_src <= src_d;
    end
  end

endmodule

// File: doc/elbeth_load_store_unit.md
# elbeth_load_store_unit

Processor-side initiator for the ELBETH data-memory port. It takes load/store requests from the execute/memory pipeline stage and drives the `dmem_*` request interface of `elbeth_bridge_memory`. It generates byte-lane write strobes and lane-replicated store data, checks alignment locally, and applies a response timeout. It returns sign- or zero-extended load data, a one-cycle completion pulse and exception information to the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles spent in ACCESS waiting for `dmem_ready` or `dmem_except`. Legal range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `lsu_req` in 1: access request, sampled only in IDLE.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `lsu_signed` in 1: sign-extend load result when 1.
- `lsu_addr` in 32: byte address.
- `lsu_wdata` in 32: store data, right-justified.
- `lsu_busy` out 1: high in ACCESS and RESP.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_rdata` out 32: extended load data. Valid while `lsu_done` is high.
- `lsu_except` out 1: exception flag. Valid while `lsu_done` is high.
- `lsu_except_src` out 4: exception code.
- `dmem_en` out 1: request enable to the bridge.
- `dmem_addr` out 32: word address, with bits [1:0] forced to 0.
- `dmem_out_data` out 32: store data, lane-replicated.
- `dmem_rw` out 4: byte write strobes. 0000 = read.
- `dmem_in_data` in 32: read data from the bridge.
- `dmem_ready` in 1: access complete.
- `dmem_except` in 1: bridge or memory exception.
- `dmem_except_src` in 4: bridge exception code.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, `lsu_req`=1: capture `lsu_we`, `lsu_size`, `lsu_signed`, `lsu_addr` and `lsu_wdata`, then run the local checks below.
  - `lsu_size`=11: go to RESP with code 4'h4. No bus access.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]≠0): go to RESP with code 4'h1 for a load or 4'h2 for a store. No bus access.
  - Otherwise go to ACCESS and clear the timeout counter.
- ACCESS:
  - `dmem_en`=1. `dmem_addr`, `dmem_rw` and `dmem_out_data` are registered and held stable for the whole state.
  - Exit to RESP on the first edge where `dmem_ready` or `dmem_except` is high, or when the counter reaches `TIMEOUT`. The timeout sets code 4'h3.
- RESP: `lsu_done`=1 for exactly one cycle, then return to IDLE.
- Strobes (little-endian, lane k = bits [8k+7:8k], k = addr[1:0]):
  - load: 0000
  - byte store: 0001 << k
  - half store: 0011 << k
  - word store: 1111
- Store data:
  - byte: `lsu_wdata[7:0]` replicated ×4
  - half: `lsu_wdata[15:0]` replicated ×2
  - word: unchanged
- Load result: take the lane selected by addr[1:0] from `dmem_in_data`, registered on the ready edge. Sign-extend if `lsu_signed`=1, else zero-extend. Word loads ignore `lsu_signed`. Store completion gives `lsu_rdata`=0.
- Exception priority when several conditions occur on the same edge: `dmem_except` > `dmem_ready` > timeout.
  - On `dmem_except`: `lsu_except_src` = `dmem_except_src`, `lsu_rdata` = 0.
  - Any exception sets `lsu_except`=1.
- `lsu_req` seen while busy is ignored. The pipeline keeps it asserted until `lsu_done` and drops it in the `lsu_done` cycle.

## Timing
- Reset values: every output is 0 (`dmem_en`, `dmem_addr`, `dmem_out_data`, `dmem_rw`, `lsu_*`); state is IDLE; counter is 0.
- Reset asserted mid-access aborts immediately. No `lsu_done` is issued and the request is lost.
- Latency:
  - Request accepted at edge N: `dmem_en` rises after edge N.
  - Ready sampled at edge M: `lsu_done` high from after edge M until edge M+1.
  - Minimum load-use latency is 2 edges (ready on the first ACCESS edge).
  - Local exception: `lsu_done` after edge N+1. `dmem_en` never rises.
- Timeout: with no response, `lsu_done` with code 4'h3 is high for the cycle after the `TIMEOUT`-th ACCESS edge.
- `dmem_en` drops in the RESP cycle. Back-to-back requests give at least one `dmem_en`-low cycle between accesses (RESP plus IDLE).
- `dmem_ready` or `dmem_except` arriving outside ACCESS is ignored.

## Test plan
- Word load: addr 0x8 with memory word 0xA1B2C3D4 → `dmem_rw`=0000, `dmem_addr`=0x8; `lsu_rdata`=0xA1B2C3D4, `lsu_done` one cycle, `lsu_except`=0.
- Byte store then loads: store 0xBA at 0x11E, size byte → `dmem_addr`=0x11C, `dmem_rw`=0100, `dmem_out_data`=0xBABABABA. Then:
  - signed byte load at 0x11E → 0xFFFFFFBA
  - unsigned byte load at 0x11E → 0x000000BA
- Misalignment and illegal size:
  - word load at 0x3 → no `dmem_en`; `lsu_except`=1, code 4'h1, done at N+1
  - half store at 0x5 → code 4'h2
  - `lsu_size`=11 → code 4'h4
- Timeout: `TIMEOUT`=4, responder never raises ready → `dmem_en` high for exactly 4 cycles, then done with code 4'h3.
- Bridge exception: `dmem_except`=1 with src 4'h6, asserted together with `dmem_ready` → code 4'h6, `lsu_rdata`=0.
- Reset mid-access: `rst` low during ACCESS → all outputs 0 asynchronously and no `lsu_done`. After release, a new word load completes normally.
